fft2_din_buffer: RTL and testbench

//  Frame buffer directly upstream of the fft2 core input port. Accepts a row-major stream of
//  FFT_SIZE*FFT_SIZE complex samples and serves them to the core's random-address read port
//  (core addr/rd strobe in, RE/IM data + rd-valid back). Core starts on frame_rdy_o and

---
 rtl/fft2_pkg.sv | 15 +
 rtl/fft2_din_bank.sv | 25 ++
 rtl/fft2_din_buffer.sv | 97 +++++++++
 tb/tb_fft2_din_buffer.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/fft2_pkg.sv
// fft2_pkg: shared types and sizing helpers for the fft2 input buffer
package fft2_pkg;
  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_FFT_SIZE = 16;
  typedef struct packed {
    logic [DEF_DATA_WIDTH-1:0] re;
    logic [DEF_DATA_WIDTH-1:0] im;
  } complex_t;
  typedef enum logic [1:0] {EMPTY, FILLING, FULL} bank_state_e;
  function automatic int frame_depth(input int n);
    return n * n;
  endfunction
  localparam int DEF_DEPTH = frame_depth(DEF_FFT_SIZE);
  localparam int DEF_ADDR_W = $clog2(DEF_DEPTH);
endpackage

// File: rtl/fft2_din_bank.sv
// fft2_din_bank: simple dual-port frame RAM, one write port, one registered read port
module fft2_din_bank
  import fft2_pkg::*;
#(
  parameter int WIDTH = 2 * DEF_DATA_WIDTH,
  parameter int DEPTH = DEF_DEPTH,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [WIDTH-1:0]  wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [WIDTH-1:0]  rdata
);
  logic [WIDTH-1:0] mem [DEPTH];
  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;
  // read register holds its value between reads so the core sees stable data
  always_ff @(posedge clk or negedge rst)
    if (!rst) rdata <= '0;
    else if (re) rdata <= mem[raddr];
endmodule

// File: rtl/fft2_din_buffer.sv
// fft2_din_buffer: frame buffer feeding the fft2 core's random-access input port.
// FFT2_DIN_PINGPONG_EN selects two ping-pong banks; otherwise a single bank is used.
module fft2_din_buffer
  import fft2_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int FFT_SIZE = DEF_FFT_SIZE,
  localparam int DEPTH = frame_depth(FFT_SIZE),
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  s_valid_i,
  output logic                  s_ready_o,
  input  logic [DATA_WIDTH-1:0] s_re_i,
  input  logic [DATA_WIDTH-1:0] s_im_i,
  input  logic                  s_last_i,
  input  logic [ADDR_W-1:0]     rd_addr_i,
  input  logic                  rd_en_i,
  output logic [DATA_WIDTH-1:0] rd_re_o,
  output logic [DATA_WIDTH-1:0] rd_im_o,
  output logic                  rd_valid_o,
  output logic                  frame_rdy_o,
  input  logic                  frame_done_i,
  output logic                  frame_err_o,
  output logic                  rd_err_o
);
`ifdef FFT2_DIN_PINGPONG_EN
  localparam bit PP = 1'b1;
`else
  localparam bit PP = 1'b0;
`endif
  localparam int W = 2 * DATA_WIDTH;
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);
  bank_state_e state_q [2];
  bank_state_e state_d [2];
  logic [ADDR_W-1:0] wr_ptr_q;
  logic wr_bank_q, rd_bank_q, rd_sel_q, wr_bank_d, rd_bank_d;
  logic wr_fire, wr_last, rd_fire, done;
  logic [W-1:0] rdata [2];
  assign wr_fire = s_valid_i & s_ready_o;
  assign wr_last = wr_ptr_q == LAST;
  assign rd_fire = rd_en_i & frame_rdy_o;
  assign done = frame_done_i & frame_rdy_o;
  // bank selects only ever move when ping-pong is enabled
  assign wr_bank_d = wr_bank_q ^ (PP & wr_fire & wr_last);
  assign rd_bank_d = rd_bank_q ^ (PP & done);
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      state_d[i] = state_q[i];
      if (wr_fire && wr_bank_q == i[0]) state_d[i] = wr_last ? FULL : FILLING;
      if (done && rd_bank_q == i[0]) state_d[i] = EMPTY;
    end
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state_q[0]  <= EMPTY;
      state_q[1]  <= EMPTY;
      wr_ptr_q    <= '0;
      wr_bank_q   <= 1'b0;
      rd_bank_q   <= 1'b0;
      rd_sel_q    <= 1'b0;
      s_ready_o   <= 1'b0;
      frame_rdy_o <= 1'b0;
      rd_valid_o  <= 1'b0;
      rd_err_o    <= 1'b0;
      frame_err_o <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_fire ? (wr_last ? '0 : wr_ptr_q + 1'b1) : wr_ptr_q;
      wr_bank_q   <= wr_bank_d;
      rd_bank_q   <= rd_bank_d;
      rd_sel_q    <= rd_fire ? rd_bank_q : rd_sel_q;
      s_ready_o   <= state_d[wr_bank_d] != FULL;
      frame_rdy_o <= !done && state_q[rd_bank_q] == FULL;
      rd_valid_o  <= rd_fire;
      rd_err_o    <= rd_en_i & ~frame_rdy_o;
      frame_err_o <= wr_fire & (s_last_i ^ wr_last);
    end
  for (genvar b = 0; b < 2; b++) begin : g_bank
    if (b == 0 || PP) begin : g_ram
      fft2_din_bank #(.WIDTH(W), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_bank (
        .clk   (clk),
        .rst   (rst),
        .we    (wr_fire && wr_bank_q == 1'(b)),
        .waddr (wr_ptr_q),
        .wdata ({s_re_i, s_im_i}),
        .re    (rd_fire && rd_bank_q == 1'(b)),
        .raddr (rd_addr_i),
        .rdata (rdata[b])
      );
    end else begin : g_none
      assign rdata[b] = '0;
    end
  end
  assign {rd_re_o, rd_im_o} = rd_sel_q ? rdata[1] : rdata[0];
endmodule

// File: tb/tb_fft2_din_buffer.sv
// tb_fft2_din_buffer: randomized scoreboard bench for fft2_din_buffer (FFT_SIZE=4)
module tb_fft2_din_buffer;
  localparam int DEPTH = 16;
`ifdef FFT2_DIN_PINGPONG_EN
  localparam int NB = 2;
`else
  localparam int NB = 1;
`endif
  typedef struct {
    int          due;
    bit          err;
    logic [63:0] data;
  } rd_exp_t;
  logic clk = 0, rst = 0, s_valid_i = 0, s_last_i = 0, rd_en_i = 0, frame_done_i = 0;
  logic [31:0] s_re_i = 0, s_im_i = 0;
  logic [3:0] rd_addr_i = 0;
  logic s_ready_o, rd_valid_o, frame_rdy_o, frame_err_o, rd_err_o;
  logic [31:0] rd_re_o, rd_im_o;
  int checks = 0, failures = 0, cyc = 0, nfull = 0;
  logic [63:0] full_q[$];
  logic [63:0] cur[$];
  rd_exp_t rd_q[$];
  int ferr_q[$];

  fft2_din_buffer #(.DATA_WIDTH(32), .FFT_SIZE(4)) dut (
    .clk(clk), .rst(rst), .s_valid_i(s_valid_i), .s_ready_o(s_ready_o),
    .s_re_i(s_re_i), .s_im_i(s_im_i), .s_last_i(s_last_i),
    .rd_addr_i(rd_addr_i), .rd_en_i(rd_en_i), .rd_re_o(rd_re_o), .rd_im_o(rd_im_o),
    .rd_valid_o(rd_valid_o), .frame_rdy_o(frame_rdy_o), .frame_done_i(frame_done_i),
    .frame_err_o(frame_err_o), .rd_err_o(rd_err_o)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at cycle %0d", nm, act, exp, cyc);
    end
  endtask

  // monitor: every read response and frame error pulse must land on the cycle the model predicts
  always @(negedge clk) begin
    rd_exp_t e;
    if (rst) begin
      if (rd_q.size() > 0 && rd_q[0].due == cyc) begin
        e = rd_q.pop_front();
        chk("rd_valid", rd_valid_o, !e.err);
        chk("rd_err", rd_err_o, e.err);
        if (!e.err) chk("rd_data", {rd_re_o, rd_im_o}, e.data);
      end else if (rd_valid_o || rd_err_o) chk("rd_spurious", {rd_valid_o, rd_err_o}, 0);
      if (ferr_q.size() > 0 && ferr_q[0] == cyc) begin
        void'(ferr_q.pop_front());
        chk("frame_err", frame_err_o, 1);
      end else if (frame_err_o) chk("frame_err_spurious", frame_err_o, 0);
    end
  end

  task automatic reset_seq();
    rst = 0;
    cur.delete(); full_q.delete(); rd_q.delete(); ferr_q.delete(); nfull = 0;
    @(negedge clk);
    chk("rst_s_ready", s_ready_o, 0);
    chk("rst_rd_valid", rd_valid_o, 0);
    chk("rst_frame_rdy", frame_rdy_o, 0);
    chk("rst_frame_err", frame_err_o, 0);
    chk("rst_rd_err", rd_err_o, 0);
    chk("rst_rd_data", {rd_re_o, rd_im_o}, 0);
    rst = 1;
    @(negedge clk);
    chk("s_ready_after_rst", s_ready_o, 1);
    @(posedge clk); #1;
  endtask

  task automatic put(input logic [31:0] re, input logic [31:0] im, input bit last);
    int n = 0;
    s_valid_i = 1; s_re_i = re; s_im_i = im; s_last_i = last;
    @(negedge clk);
    while (!s_ready_o && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (!s_ready_o) begin
      chk("s_ready_wait", s_ready_o, 1);
      s_valid_i = 0; s_last_i = 0;
      return;
    end
    @(posedge clk); #1;
    if (last != (cur.size() == DEPTH - 1)) ferr_q.push_back(cyc);
    cur.push_back({re, im});
    if (cur.size() == DEPTH) begin
      full_q = {full_q, cur};
      cur.delete();
      nfull++;
    end
    s_valid_i = 0; s_last_i = 0;
  endtask

  // bad: beat index carrying a stray last, -2 drops last on the final beat
  task automatic frame(input bit rnd, input int bad, input bit chk_end);
    for (int i = 0; i < DEPTH; i++)
      put(rnd ? $urandom : 32'(i), rnd ? $urandom : 32'(-i),
          (i == DEPTH - 1 && bad != -2) || i == bad);
    if (chk_end) begin
      @(negedge clk);
      chk("s_ready_frame_end", s_ready_o, nfull < NB);
      @(posedge clk); #1;
    end
  endtask

  task automatic release_model();
    repeat (DEPTH) void'(full_q.pop_front());
    nfull--;
  endtask

  task automatic rd(input int a, input bit with_done);
    rd_exp_t e;
    rd_en_i = 1; rd_addr_i = a[3:0]; frame_done_i = with_done;
    e.due = cyc + 1;
    e.err = nfull == 0;
    e.data = nfull > 0 ? full_q[a] : '0;
    rd_q.push_back(e);
    @(posedge clk); #1;
    rd_en_i = 0; frame_done_i = 0;
    if (with_done && nfull > 0) release_model();
  endtask

  task automatic done_task();
    frame_done_i = 1;
    @(posedge clk); #1;
    frame_done_i = 0;
    if (nfull > 0) release_model();
    @(negedge clk);
    chk("frame_rdy_after_done", frame_rdy_o, 0);
    @(posedge clk); #1;
  endtask

  task automatic wait_rdy();
    int n = 0;
    @(negedge clk);
    while (!frame_rdy_o && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk("frame_rdy_wait", frame_rdy_o, 1);
    @(posedge clk); #1;
  endtask

  task automatic read_all_shuffled();
    int ord[DEPTH];
    for (int i = 0; i < DEPTH; i++) ord[i] = i;
    for (int i = DEPTH - 1; i > 0; i--) begin
      int j = $urandom_range(i, 0);
      int t = ord[i];
      ord[i] = ord[j];
      ord[j] = t;
    end
    for (int i = 0; i < DEPTH; i++) rd(ord[i], 0);
  endtask

  initial begin
    reset_seq();
    // read and release with nothing buffered
    rd(5, 0);
    repeat (2) @(posedge clk);
    #1;
    done_task();
    // ramp frame, frame_rdy timing, sequential read-back
    frame(0, -1, 0);
    @(negedge clk);
    chk("frame_rdy_early", frame_rdy_o, 0);
    @(negedge clk);
    chk("frame_rdy_2cyc", frame_rdy_o, 1);
    chk("s_ready_full", s_ready_o, nfull < NB);
    @(posedge clk); #1;
    for (int a = 0; a < DEPTH; a++) rd(a, 0);
    done_task();
    // stray last on beat 9, scattered reads, read together with release
    frame(1, 9, 1);
    wait_rdy();
    rd(15, 0); rd(3, 0); rd(7, 0);
    repeat (8) rd($urandom_range(DEPTH - 1, 0), 0);
    rd($urandom_range(DEPTH - 1, 0), 1);
    @(negedge clk);
    chk("frame_rdy_after_rd_done", frame_rdy_o, 0);
    @(posedge clk); #1;
    // missing last on the final beat
    frame(1, -2, 1);
    wait_rdy();
    repeat (4) rd($urandom_range(DEPTH - 1, 0), 0);
    done_task();
    // continuous writer against a slow core
    fork
      begin
        repeat (3) frame(1, -1, 1);
      end
      begin
        repeat (3) begin
          wait_rdy();
          read_all_shuffled();
          repeat (40) @(posedge clk);
          #1;
          done_task();
        end
      end
    join
    // reset in the middle of a frame, then a clean frame
    repeat (7) put($urandom, $urandom, 0);
    reset_seq();
    frame(1, -1, 1);
    wait_rdy();
    read_all_shuffled();
    done_task();
    repeat (3) @(posedge clk);
    #1;
    chk("rd_queue_drained", rd_q.size(), 0);
    chk("frame_err_queue_drained", ferr_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
